// File: rtl/pipelined_shifter_if.sv
// Handshake bundle for pipelined_shifter: operation request in, shifted result out.
// The master drives operations and consumes results; the shifter is the slave.
interface pipelined_shifter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
);
    localparam int unsigned AW = $clog2(WIDTH);

    logic             In_valid;
    logic             In_ready;
    logic [WIDTH-1:0] In_a;
    logic [AW-1:0]    In_amt;
    logic [2:0]       In_op;
    logic [TAG_W-1:0] In_tag;

    logic             Out_valid;
    logic             Out_ready;
    logic [WIDTH-1:0] Out_y;
    logic [TAG_W-1:0] Out_tag;
    logic             Out_illegal;

    modport master (
        output In_valid, In_a, In_amt, In_op, In_tag, Out_ready,
        input  In_ready, Out_valid, Out_y, Out_tag, Out_illegal
    );

    modport slave (
        input  In_valid, In_a, In_amt, In_op, In_tag, Out_ready,
        output In_ready, Out_valid, Out_y, Out_tag, Out_illegal
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter/rotator: log2(WIDTH) mux levels spread over STAGES
// elastic register stages, with tag pass-through, flush and reserved-op flagging.
module pipelined_shifter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Flush,
    pipelined_shifter_if.slave  bus
);
    localparam int unsigned L = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    // Stage registers
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] data_q  [STAGES];
    logic [L-1:0]     amt_q   [STAGES];
    op_e              op_q    [STAGES];
    logic             sign_q  [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];
    logic             ill_q   [STAGES];

    // Values presented to the input side of each stage
    logic             s_valid [STAGES];
    logic [WIDTH-1:0] s_data  [STAGES];
    logic [L-1:0]     s_amt   [STAGES];
    op_e              s_op    [STAGES];
    logic             s_sign  [STAGES];
    logic [TAG_W-1:0] s_tag   [STAGES];
    logic             s_ill   [STAGES];

    logic [WIDTH-1:0] data_d  [STAGES];
    logic             adv     [STAGES];
    logic             in_ready;
    logic             illegal_in;

    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input op_e              op,
        input logic             sign,
        input int unsigned      sh
    );
        case (op)
            OP_SLL:  return d << sh;
            OP_SRL:  return d >> sh;
            OP_SRA:  return (d >> sh) | ({WIDTH{sign}} << (WIDTH - sh));
            OP_ROL:  return (d << sh) | (d >> (WIDTH - sh));
            OP_ROR:  return (d >> sh) | (d << (WIDTH - sh));
            default: return d;
        endcase
    endfunction

    // A stage may load when it is empty or its occupant moves on this cycle.
    always_comb begin
        adv[STAGES-1] = !valid_q[STAGES-1] | bus.Out_ready;
        for (int unsigned k = 1; k < STAGES; k++) begin
            adv[STAGES-1-k] = !valid_q[STAGES-1-k] | adv[STAGES-k];
        end
    end

    assign in_ready   = Reset_n & ~Flush & adv[0];
    assign illegal_in = bus.In_op > 3'd4;

    // Reserved ops enter with zero data and sign so every level yields zero.
    always_comb begin
        s_valid[0] = bus.In_valid & in_ready;
        s_data[0]  = illegal_in ? '0 : bus.In_a;
        s_amt[0]   = bus.In_amt;
        s_op[0]    = op_e'(bus.In_op);
        s_sign[0]  = ~illegal_in & bus.In_a[WIDTH-1];
        s_tag[0]   = bus.In_tag;
        s_ill[0]   = illegal_in;
        for (int unsigned s = 1; s < STAGES; s++) begin
            s_valid[s] = valid_q[s-1];
            s_data[s]  = data_q[s-1];
            s_amt[s]   = amt_q[s-1];
            s_op[s]    = op_q[s-1];
            s_sign[s]  = sign_q[s-1];
            s_tag[s]   = tag_q[s-1];
            s_ill[s]   = ill_q[s-1];
        end
    end

    // Level i (shift 2^(L-1-i)) is evaluated in stage floor(i*STAGES/L).
    always_comb begin
        for (int unsigned s = 0; s < STAGES; s++) begin
            data_d[s] = s_data[s];
            for (int unsigned i = 0; i < L; i++) begin
                if (((i * STAGES) / L) == s && s_amt[s][L-1-i]) begin
                    data_d[s] = shift_level(data_d[s], s_op[s], s_sign[s], 32'd1 << (L - 1 - i));
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                valid_q[s] <= 1'b0;
                data_q[s]  <= '0;
                amt_q[s]   <= '0;
                op_q[s]    <= OP_SLL;
                sign_q[s]  <= 1'b0;
                tag_q[s]   <= '0;
                ill_q[s]   <= 1'b0;
            end
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                if (Flush) begin
                    valid_q[s] <= 1'b0;
                end else if (adv[s]) begin
                    valid_q[s] <= s_valid[s];
                    if (s_valid[s]) begin
                        data_q[s] <= data_d[s];
                        amt_q[s]  <= s_amt[s];
                        op_q[s]   <= s_op[s];
                        sign_q[s] <= s_sign[s];
                        tag_q[s]  <= s_tag[s];
                        ill_q[s]  <= s_ill[s];
                    end
                end
            end
        end
    end

    assign bus.In_ready    = in_ready;
    assign bus.Out_valid   = valid_q[STAGES-1];
    assign bus.Out_y       = data_q[STAGES-1];
    assign bus.Out_tag     = tag_q[STAGES-1];
    assign bus.Out_illegal = ill_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench: directed vectors, streaming/backpressure, flush and reset on a
// 32/2 instance, plus random sweeps of 8/1, 64/6 and 32/5 against a reference model.
module tb_pipelined_shifter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m = 1'b1;
    logic rst_s = 1'b0;
    logic flush_m = 1'b0;
    logic flush_s = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   sweep_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- main 32/2 instance ----------------
    pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) mbus ();
    pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_dut (
        .Clk(clk), .Reset_n(rst_m), .Flush(flush_m), .bus(mbus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [4:0]  amt;
        logic [4:0]  tag;
        logic [31:0] y;
        logic        ill;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [31:0] ref32(input logic [31:0] a, input logic [4:0] amt,
                                          input logic [2:0] op);
        logic [63:0] dbl;
        dbl = {a, a};
        case (op)
            3'd0: ref32 = a << amt;
            3'd1: ref32 = a >> amt;
            3'd2: ref32 = $signed(a) >>> amt;
            3'd3: begin dbl = dbl << amt; ref32 = dbl[63:32]; end
            3'd4: begin dbl = dbl >> amt; ref32 = dbl[31:0]; end
            default: ref32 = '0;
        endcase
    endfunction

    task automatic drive_in(input logic [2:0] op, input logic [31:0] a, input logic [4:0] amt,
                            input logic [4:0] tag);
        mbus.In_op  = op;
        mbus.In_a   = a;
        mbus.In_amt = amt;
        mbus.In_tag = tag;
    endtask

    task automatic do_vec(input vec_t v);
        @(negedge clk);
        drive_in(v.op, v.a, v.amt, v.tag);
        mbus.In_valid  = 1'b1;
        mbus.Out_ready = 1'b1;
        #1 chk("vec_in_ready", mbus.In_ready, 1);
        @(posedge clk);
        #1 mbus.In_valid = 1'b0;
        chk("vec_ov_early", mbus.Out_valid, 0);
        @(posedge clk);
        #1 chk("vec_ov", mbus.Out_valid, 1);
        chk($sformatf("vec_y_t%0d", v.tag), mbus.Out_y, v.y);
        chk("vec_tag", mbus.Out_tag, v.tag);
        chk("vec_ill", mbus.Out_illegal, v.ill);
        @(posedge clk);
        #1 chk("vec_ov_consumed", mbus.Out_valid, 0);
    endtask

    task automatic gen_op(input int k, output logic [2:0] op, output logic [31:0] a,
                          output logic [4:0] amt);
        a   = 32'(32'h9E3779B9 * (k + 1));
        op  = (k % 8 == 7) ? 3'b110 : 3'(k % 5);
        amt = 5'((k * 7 + 3) % 32);
    endtask

    // rnd=1: random Out_ready with ready/stability checks; rnd=0: Out_ready held high
    // and each op must be consumed exactly 2 edges after its accept edge.
    task automatic run_stream(input int n, input bit rnd);
        logic [31:0] qy[$];
        logic [4:0]  qt[$];
        int          qc[$];
        int          sent = 0, got = 0, cyc = 0;
        logic        pv = 1'b0;
        logic [31:0] py;
        logic [4:0]  pt;
        logic [2:0]  op;
        logic [31:0] a;
        logic [4:0]  amt;
        while (got < n && cyc < 400) begin
            @(negedge clk);
            mbus.Out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < n) begin
                gen_op(sent, op, a, amt);
                drive_in(op, a, amt, 5'(sent));
                mbus.In_valid = 1'b1;
            end else begin
                mbus.In_valid = 1'b0;
            end
            #1;
            if (rnd) chk("str_in_ready", mbus.In_ready, (qy.size() < 2) || mbus.Out_ready);
            else if (sent < n) chk("full_in_ready", mbus.In_ready, 1);
            if (pv) begin
                chk("stall_ov", mbus.Out_valid, 1);
                chk("stall_y", mbus.Out_y, py);
                chk("stall_tag", mbus.Out_tag, pt);
            end
            pv = mbus.Out_valid & ~mbus.Out_ready;
            py = mbus.Out_y;
            pt = mbus.Out_tag;
            if (mbus.Out_valid && mbus.Out_ready) begin
                if (qy.size() == 0) begin
                    chk("str_spurious", 1, 0);
                end else begin
                    chk("str_y", mbus.Out_y, qy[0]);
                    chk("str_tag", mbus.Out_tag, qt[0]);
                    if (!rnd) chk("str_latency", cyc - qc[0], 2);
                    void'(qy.pop_front());
                    void'(qt.pop_front());
                    void'(qc.pop_front());
                end
                got++;
            end
            if (mbus.In_valid && mbus.In_ready) begin
                qy.push_back(ref32(a, amt, op));
                qt.push_back(5'(sent));
                qc.push_back(cyc);
                sent++;
            end
            cyc++;
        end
        chk("str_count", got, n);
        @(negedge clk);
        mbus.In_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'h0000FFFF, 5'd16, 5'd1,  32'hFFFF0000, 1'b0};
        vecs[1]  = '{3'd1, 32'h80000000, 5'd31, 5'd2,  32'h00000001, 1'b0};
        vecs[2]  = '{3'd2, 32'h80000000, 5'd4,  5'd3,  32'hF8000000, 1'b0};
        vecs[3]  = '{3'd4, 32'h00000001, 5'd1,  5'd4,  32'h80000000, 1'b0};
        vecs[4]  = '{3'd3, 32'h80000001, 5'd4,  5'd5,  32'h00000018, 1'b0};
        vecs[5]  = '{3'd0, 32'hA5A50F0F, 5'd0,  5'd6,  32'hA5A50F0F, 1'b0};
        vecs[6]  = '{3'd1, 32'hA5A50F0F, 5'd0,  5'd7,  32'hA5A50F0F, 1'b0};
        vecs[7]  = '{3'd2, 32'hA5A50F0F, 5'd0,  5'd8,  32'hA5A50F0F, 1'b0};
        vecs[8]  = '{3'd3, 32'hA5A50F0F, 5'd0,  5'd9,  32'hA5A50F0F, 1'b0};
        vecs[9]  = '{3'd4, 32'hA5A50F0F, 5'd0,  5'd10, 32'hA5A50F0F, 1'b0};
        vecs[10] = '{3'd6, 32'hDEADBEEF, 5'd3,  5'd11, 32'h00000000, 1'b1};
        vecs[11] = '{3'd5, 32'h12345678, 5'd0,  5'd12, 32'h00000000, 1'b1};
        vecs[12] = '{3'd7, 32'hFFFFFFFF, 5'd31, 5'd31, 32'h00000000, 1'b1};
        vecs[13] = '{3'd2, 32'h7FFFFFF0, 5'd4,  5'd13, 32'h07FFFFFF, 1'b0};
        vecs[14] = '{3'd3, 32'h12345678, 5'd8,  5'd14, 32'h34567812, 1'b0};
        vecs[15] = '{3'd4, 32'h12345678, 5'd8,  5'd15, 32'h78123456, 1'b0};
        vecs[16] = '{3'd1, 32'hFFFFFFFF, 5'd1,  5'd16, 32'h7FFFFFFF, 1'b0};
        vecs[17] = '{3'd2, 32'hFFFFFFFF, 5'd31, 5'd17, 32'hFFFFFFFF, 1'b0};

        mbus.In_valid  = 1'b0;
        mbus.Out_ready = 1'b0;
        drive_in(3'd0, 32'h0, 5'd0, 5'd0);

        // Reset state
        #1 rst_m = 1'b0;
        #2;
        chk("rst_in_ready", mbus.In_ready, 0);
        chk("rst_ov", mbus.Out_valid, 0);
        chk("rst_y", mbus.Out_y, 0);
        chk("rst_tag", mbus.Out_tag, 0);
        chk("rst_ill", mbus.Out_illegal, 0);
        #19 rst_m = 1'b1;
        #1 chk("idle_in_ready", mbus.In_ready, 1);

        for (int i = 0; i < 18; i++) do_vec(vecs[i]);

        run_stream(16, 1'b1);
        run_stream(8, 1'b0);

        // Flush with a full pipeline and an input presented in the flush cycle
        @(negedge clk);
        mbus.Out_ready = 1'b0;
        drive_in(3'd0, 32'h1, 5'd1, 5'd20);
        mbus.In_valid = 1'b1;
        @(negedge clk);
        drive_in(3'd0, 32'h1, 5'd2, 5'd21);
        @(negedge clk);
        chk("pre_flush_ov", mbus.Out_valid, 1);
        chk("pre_flush_full", mbus.In_ready, 0);
        drive_in(3'd0, 32'h1, 5'd3, 5'd22);
        flush_m = 1'b1;
        mbus.Out_ready = 1'b1;
        #1 chk("flush_in_ready", mbus.In_ready, 0);
        @(posedge clk);
        #1 flush_m = 1'b0;
        mbus.In_valid = 1'b0;
        chk("flush_ov", mbus.Out_valid, 0);
        @(posedge clk);
        #1 chk("flush_no_late_ov", mbus.Out_valid, 0);
        do_vec(vecs[4]);

        // Asynchronous reset mid-stream
        @(negedge clk);
        mbus.Out_ready = 1'b0;
        drive_in(3'd0, 32'h1, 5'd0, 5'd3);
        mbus.In_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("prerst_ov", mbus.Out_valid, 1);
        #2 rst_m = 1'b0;
        #1;
        chk("arst_ov", mbus.Out_valid, 0);
        chk("arst_y", mbus.Out_y, 0);
        chk("arst_tag", mbus.Out_tag, 0);
        chk("arst_ill", mbus.Out_illegal, 0);
        chk("arst_in_ready", mbus.In_ready, 0);
        mbus.In_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_m = 1'b1;
        mbus.Out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("postrst_ov", mbus.Out_valid, 0);
            chk("postrst_in_ready", mbus.In_ready, 1);
        end

        wait (sweep_done == 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial #23 rst_s = 1'b1;

    // ---------------- parameter sweep ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int unsigned W  = (g == 0) ? 8 : (g == 1) ? 64 : 32;
        localparam int unsigned S  = (g == 0) ? 1 : (g == 1) ? 6 : 5;
        localparam int unsigned AW = $clog2(W);
        localparam int          N  = 10000;

        pipelined_shifter_if #(.WIDTH(W), .TAG_W(16)) sb ();
        pipelined_shifter #(.WIDTH(W), .STAGES(S), .TAG_W(16)) u_sw (
            .Clk(clk), .Reset_n(rst_s), .Flush(flush_s), .bus(sb)
        );

        function automatic logic [W-1:0] ref_f(input logic [W-1:0] a, input logic [AW-1:0] amt,
                                               input logic [2:0] op);
            logic [2*W-1:0] dbl;
            dbl = {a, a};
            case (op)
                3'd0: ref_f = a << amt;
                3'd1: ref_f = a >> amt;
                3'd2: ref_f = $signed(a) >>> amt;
                3'd3: begin dbl = dbl << amt; ref_f = dbl[2*W-1:W]; end
                3'd4: begin dbl = dbl >> amt; ref_f = dbl[W-1:0]; end
                default: ref_f = '0;
            endcase
        endfunction

        initial begin
            logic [W-1:0] qy[$];
            logic [16:0]  qt[$];
            int           qc[$];
            int           sent = 0, got = 0, cyc = 0;
            logic         pend = 1'b0;
            logic [63:0]  r;
            logic [W-1:0] ex_y;
            sb.In_valid  = 1'b0;
            sb.Out_ready = 1'b0;
            sb.In_a      = '0;
            sb.In_amt    = '0;
            sb.In_op     = '0;
            sb.In_tag    = '0;
            wait (rst_s == 1'b1);
            while (got < N && cyc < 40000) begin
                @(negedge clk);
                sb.Out_ready = (cyc < 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (!pend && sent < N) begin
                    r         = {$urandom(), $urandom()};
                    sb.In_a   = r[W-1:0];
                    sb.In_amt = AW'($urandom_range(0, W - 1));
                    sb.In_op  = 3'($urandom_range(0, 7));
                    sb.In_tag = 16'(sent);
                    ex_y      = ref_f(sb.In_a, sb.In_amt, sb.In_op);
                    pend      = 1'b1;
                end
                sb.In_valid = pend;
                #1;
                if (sb.Out_valid && sb.Out_ready) begin
                    if (qy.size() == 0) begin
                        chk($sformatf("sw%0d_spurious", W), 1, 0);
                    end else begin
                        chk($sformatf("sw%0d_y", W), sb.Out_y, qy[0]);
                        chk($sformatf("sw%0d_tag_ill", W), {sb.Out_illegal, sb.Out_tag}, qt[0]);
                        if (cyc < 300) chk($sformatf("sw%0d_latency", W), cyc - qc[0], S);
                        void'(qy.pop_front());
                        void'(qt.pop_front());
                        void'(qc.pop_front());
                    end
                    got++;
                end
                if (sb.In_valid && sb.In_ready) begin
                    qy.push_back(ex_y);
                    qt.push_back({sb.In_op > 3'd4, sb.In_tag});
                    qc.push_back(cyc);
                    pend = 1'b0;
                    sent++;
                end
                cyc++;
            end
            chk($sformatf("sw%0d_count", W), got, N);
            sweep_done++;
        end
    end
endmodule
